// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: the selection
// policy enumeration and the select-width helper.
package mux_pkg;

    // Selection policy: SEL follows the external select, RR rotates fairly.
    typedef enum logic [0:0] {
        SEL = 1'b0,
        RR  = 1'b1
    } mux_mode_e;

    // Width of a channel index: clog2(n), never below one bit.
    function automatic int selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Searches req upward from ptr, wrapping N-1 -> 0,
// and grants the first requester. When advance is high and something was
// granted, ptr moves to one past the winner; otherwise ptr holds.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = selw(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic [SELW-1:0] ptr;
    logic            found;

    // Two passes: first the channels at or above ptr, then the wrapped-around
    // channels below ptr. Only constant indices into req are used.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SELW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SELW'(i);
            end
        end
    end

    // Pointer moves past the winner on a transfer so it has lowest priority next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            if (int'(grant_idx) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_stream.sv
// N-to-1 stream multiplexer with a one-entry registered output stage.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. A producer never retracts valid or changes data
// while waiting; out_data/out_chan stay frozen while out_valid && !out_ready.
// The output register accepts a new word whenever it is empty or being
// drained in the same cycle (load), which gives one word per cycle with no
// bubble. In SEL mode in_ready is offered to channel sel from load alone, so
// it never depends on that channel's own in_valid; a transfer happens when
// the channel also presents valid. In RR mode in_ready is the arbiter grant.
module mux_n_stream
    import mux_pkg::*;
#(
    parameter  int        WIDTH = 32,
    parameter  int        N     = 4,
    parameter  mux_mode_e MODE  = SEL,
    localparam int        SELW  = selw(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan
);

    logic             load;
    logic [N-1:0]     sel_ready;
    logic [N-1:0]     rr_req;
    logic [N-1:0]     rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             rr_advance;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;

    // Output register can take a word when empty or draining; never in reset.
    assign load = reset_n && (!out_valid || out_ready);

    // Decode sel to a one-hot; out-of-range values decode to nothing.
    always_comb begin
        sel_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                sel_ready[i] = 1'b1;
            end
        end
    end

    // The arbiter only sees requests in RR mode and only when a load is possible.
    assign rr_req     = ((MODE == RR) && load) ? in_valid : '0;
    assign rr_advance = (MODE == RR) && load;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (rr_req),
        .advance   (rr_advance),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Per-mode ready offer, resulting one-hot transfer and its channel index.
    always_comb begin
        if (MODE == RR) begin
            in_ready  = rr_grant;
            grant     = rr_grant;
            grant_idx = rr_idx;
        end else begin
            in_ready  = load ? sel_ready : '0;
            grant     = in_ready & in_valid;
            grant_idx = sel;
        end
    end

    // Pick the granted channel's word out of the packed input bus.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: replace on transfer, empty on drain, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (|grant) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_stream.sv
// Bench for mux_n_stream: a SEL and an RR instance with N=4 share stimulus,
// a third SEL instance with N=3 covers the out-of-range select.
module tb_mux_n_stream;
  import mux_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=4 shared stimulus ----------------
  logic [1:0]     sel = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0] rdy_s, rdy_r;
  logic         ov_s, ov_r;
  logic [W-1:0] od_s, od_r;
  logic [1:0]   oc_s, oc_r;

  // ---------------- N=3 instance ----------------
  logic [1:0]   sel3 = '0;
  logic [2:0]   in_valid3 = '0;
  logic [3*W-1:0] in_data3 = '0;
  logic         out_ready3 = 1'b0;
  logic [2:0]   rdy3;
  logic         ov3;
  logic [W-1:0] od3;
  logic [1:0]   oc3;

  mux_n_stream #(.WIDTH(W), .N(N), .MODE(SEL)) dut_sel (
    .clk(clk), .reset_n(reset_n), .sel(sel), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s), .out_chan(oc_s));

  mux_n_stream #(.WIDTH(W), .N(N), .MODE(RR)) dut_rr (
    .clk(clk), .reset_n(reset_n), .sel(sel), .in_valid(in_valid), .in_ready(rdy_r),
    .in_data(in_data), .out_valid(ov_r), .out_ready(out_ready), .out_data(od_r), .out_chan(oc_r));

  mux_n_stream #(.WIDTH(W), .N(3), .MODE(SEL)) dut_sel3 (
    .clk(clk), .reset_n(reset_n), .sel(sel3), .in_valid(in_valid3), .in_ready(rdy3),
    .in_data(in_data3), .out_valid(ov3), .out_ready(out_ready3), .out_data(od3), .out_chan(oc3));

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  // Each instance is modelled as "output slot + (for RR) next-priority channel".
  logic         ms_valid, mr_valid;
  logic [W-1:0] ms_data, mr_data;
  int           ms_chan, mr_chan, mr_ptr;
  int           exp_gs, exp_gr;
  logic [N-1:0] exp_rdy_s, exp_rdy_r;

  function automatic logic [W-1:0] chan_word(input int c);
    return in_data[c*W +: W];
  endfunction

  task automatic model_reset();
    ms_valid = 1'b0; ms_data = '0; ms_chan = 0;
    mr_valid = 1'b0; mr_data = '0; mr_chan = 0; mr_ptr = 0;
  endtask

  // Expected ready offers and grants for the inputs currently applied.
  task automatic predict();
    exp_gs = -1; exp_gr = -1; exp_rdy_s = '0; exp_rdy_r = '0;
    if (reset_n === 1'b1) begin
      if ((!ms_valid || out_ready) && int'(sel) < N) begin
        exp_rdy_s[sel] = 1'b1;
        if (in_valid[sel]) exp_gs = int'(sel);
      end
      if (!mr_valid || out_ready) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (mr_ptr + k) % N;
          if (exp_gr < 0 && in_valid[c]) exp_gr = c;
        end
        if (exp_gr >= 0) exp_rdy_r[exp_gr] = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock: predict from current inputs, advance the model at the edge,
  // return 1 time unit after the edge.
  task automatic tick();
    predict();
    @(posedge clk);
    if (exp_gs >= 0) begin
      ms_valid = 1'b1; ms_data = chan_word(exp_gs); ms_chan = exp_gs;
    end else if (out_ready) begin
      ms_valid = 1'b0;
    end
    if (exp_gr >= 0) begin
      mr_valid = 1'b1; mr_data = chan_word(exp_gr); mr_chan = exp_gr;
      mr_ptr = (exp_gr + 1) % N;
    end else if (out_ready) begin
      mr_valid = 1'b0;
    end
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom();
  endtask

  task automatic do_reset();
    in_valid = '0;
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    in_valid = '1; out_ready = 1'b1; sel = 2'd2; randomize_data();
    sel3 = 2'd0; in_valid3 = '1; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = $urandom();
    #12;
    n_checks++; if (ov_s !== 1'b0) $display("FAIL reset_ov_s got %b exp 0", ov_s); else n_pass++;
    n_checks++; if (od_s !== '0) $display("FAIL reset_od_s got %h exp 0", od_s); else n_pass++;
    n_checks++; if (oc_s !== 2'd0) $display("FAIL reset_oc_s got %0d exp 0", oc_s); else n_pass++;
    n_checks++; if (rdy_s !== 4'b0000) $display("FAIL reset_rdy_s got %b exp 0000", rdy_s); else n_pass++;
    n_checks++; if (ov_r !== 1'b0) $display("FAIL reset_ov_r got %b exp 0", ov_r); else n_pass++;
    n_checks++; if (rdy_r !== 4'b0000) $display("FAIL reset_rdy_r got %b exp 0000", rdy_r); else n_pass++;
    n_checks++; if (ov3 !== 1'b0) $display("FAIL reset_ov3 got %b exp 0", ov3); else n_pass++;
    n_checks++; if (rdy3 !== 3'b000) $display("FAIL reset_rdy3 got %b exp 000", rdy3); else n_pass++;
    @(negedge clk);
    in_valid = '0; in_valid3 = '0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sel_basic();
    sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    randomize_data();
    in_data[2*W +: W] = 32'hA5;
    #1;
    n_checks++; if (rdy_s !== 4'b0100) $display("FAIL sel_basic_ready got %b exp 0100", rdy_s); else n_pass++;
    tick();
    in_valid = '0;
    n_checks++; if (ov_s !== 1'b1) $display("FAIL sel_basic_valid got %b exp 1", ov_s); else n_pass++;
    n_checks++; if (od_s !== 32'hA5) $display("FAIL sel_basic_data got %h exp 000000a5", od_s); else n_pass++;
    n_checks++; if (oc_s !== 2'd2) $display("FAIL sel_basic_chan got %0d exp 2", oc_s); else n_pass++;
    tick();
  endtask

  task automatic test_rr_sequence();
    logic [N*W-1:0] d;
    do_reset();
    in_valid = '1; out_ready = 1'b1;
    randomize_data();
    d = in_data;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] one;
      one = '0;
      one[k % N] = 1'b1;
      #1;
      n_checks++; if (rdy_r !== one) $display("FAIL rr_seq_ready[%0d] got %b exp %b", k, rdy_r, one); else n_pass++;
      tick();
      n_checks++; if (ov_r !== 1'b1 || oc_r !== 2'(k % N)) $display("FAIL rr_seq_chan[%0d] got v=%b ch=%0d exp v=1 ch=%0d", k, ov_r, oc_r, k % N); else n_pass++;
      n_checks++; if (od_r !== d[(k % N)*W +: W]) $display("FAIL rr_seq_data[%0d] got %h exp %h", k, od_r, d[(k % N)*W +: W]); else n_pass++;
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_rr_wrap();
    do_reset();
    out_ready = 1'b1;
    randomize_data();
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0011;
    #1;
    n_checks++; if (rdy_r !== 4'b0001) $display("FAIL rr_wrap_ready got %b exp 0001", rdy_r); else n_pass++;
    tick();
    n_checks++; if (oc_r !== 2'd0) $display("FAIL rr_wrap_chan got %0d exp 0", oc_r); else n_pass++;
    #1;
    n_checks++; if (rdy_r !== 4'b0010) $display("FAIL rr_wrap_ptr1 got %b exp 0010", rdy_r); else n_pass++;
    tick();
    n_checks++; if (oc_r !== 2'd1) $display("FAIL rr_wrap_next_chan got %0d exp 1", oc_r); else n_pass++;
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_s, held_r, nxt;
    sel = 2'd1; in_valid = '1; out_ready = 1'b1;
    randomize_data();
    held_s = in_data[1*W +: W];
    tick();
    held_r = mr_data;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomize_data();
      #1;
      n_checks++; if (rdy_s !== 4'b0000 || rdy_r !== 4'b0000) $display("FAIL bp_ready[%0d] got s=%b r=%b exp 0000", c, rdy_s, rdy_r); else n_pass++;
      tick();
      n_checks++; if (ov_s !== 1'b1 || od_s !== held_s) $display("FAIL bp_hold_s[%0d] got v=%b d=%h exp v=1 d=%h", c, ov_s, od_s, held_s); else n_pass++;
      n_checks++; if (ov_r !== 1'b1 || od_r !== held_r) $display("FAIL bp_hold_r[%0d] got v=%b d=%h exp v=1 d=%h", c, ov_r, od_r, held_r); else n_pass++;
    end
    out_ready = 1'b1; sel = 2'd3;
    nxt = in_data[3*W +: W];
    #1;
    n_checks++; if (rdy_s !== 4'b1000) $display("FAIL bp_release_ready got %b exp 1000", rdy_s); else n_pass++;
    tick();
    n_checks++; if (ov_s !== 1'b1 || od_s !== nxt || oc_s !== 2'd3) $display("FAIL bp_replace got v=%b d=%h ch=%0d exp v=1 d=%h ch=3", ov_s, od_s, oc_s, nxt); else n_pass++;
    n_checks++; if (ov_r !== 1'b1 || od_r !== mr_data) $display("FAIL bp_replace_r got v=%b d=%h exp v=1 d=%h", ov_r, od_r, mr_data); else n_pass++;
    in_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = '1; out_ready = 1'b1;
    randomize_data();
    tick();
    tick();
    n_checks++; if (ov_r !== 1'b1) $display("FAIL ares_pre_valid got %b exp 1", ov_r); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (ov_s !== 1'b0 || ov_r !== 1'b0) $display("FAIL ares_valid got s=%b r=%b exp 0", ov_s, ov_r); else n_pass++;
    n_checks++; if (od_r !== '0 || oc_r !== 2'd0) $display("FAIL ares_data got d=%h ch=%0d exp 0", od_r, oc_r); else n_pass++;
    n_checks++; if (rdy_r !== 4'b0000 || rdy_s !== 4'b0000) $display("FAIL ares_ready got s=%b r=%b exp 0000", rdy_s, rdy_r); else n_pass++;
    #2;
    reset_n = 1'b1;
    in_valid = 4'b0110;
    #1;
    n_checks++; if (rdy_r !== 4'b0010) $display("FAIL ares_first_ready got %b exp 0010", rdy_r); else n_pass++;
    tick();
    n_checks++; if (ov_r !== 1'b1 || oc_r !== 2'd1) $display("FAIL ares_first_grant got v=%b ch=%0d exp v=1 ch=1", ov_r, oc_r); else n_pass++;
    in_valid = '0;
    tick();
  endtask

  task automatic test_sel_invalid();
    sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = $urandom();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (rdy3 !== 3'b000) $display("FAIL sel3_ready[%0d] got %b exp 000", c, rdy3); else n_pass++;
      tick();
      n_checks++; if (ov3 !== 1'b0) $display("FAIL sel3_valid[%0d] got %b exp 0", c, ov3); else n_pass++;
    end
    sel3 = 2'd2;
    #1;
    n_checks++; if (rdy3 !== 3'b100) $display("FAIL sel3_ok_ready got %b exp 100", rdy3); else n_pass++;
    tick();
    n_checks++; if (ov3 !== 1'b1 || od3 !== in_data3[2*W +: W] || oc3 !== 2'd2) $display("FAIL sel3_ok_out got v=%b d=%h ch=%0d exp v=1 d=%h ch=2", ov3, od3, oc3, in_data3[2*W +: W]); else n_pass++;
    in_valid3 = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      sel = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      randomize_data();
      #1;
      predict();
      n_checks++; if (rdy_r !== exp_rdy_r) $display("FAIL rand_ready_r[%0d] got %b exp %b", c, rdy_r, exp_rdy_r); else n_pass++;
      if (in_valid[sel]) begin
        n_checks++; if (rdy_s !== exp_rdy_s) $display("FAIL rand_ready_s[%0d] got %b exp %b", c, rdy_s, exp_rdy_s); else n_pass++;
      end
      tick();
      n_checks++; if (ov_s !== ms_valid || (ms_valid && (od_s !== ms_data || int'(oc_s) != ms_chan)))
        $display("FAIL rand_out_s[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d", c, ov_s, od_s, oc_s, ms_valid, ms_data, ms_chan); else n_pass++;
      n_checks++; if (ov_r !== mr_valid || (mr_valid && (od_r !== mr_data || int'(oc_r) != mr_chan)))
        $display("FAIL rand_out_r[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d", c, ov_r, od_r, oc_r, mr_valid, mr_data, mr_chan); else n_pass++;
    end
    in_valid = '0;
    out_ready = 1'b1;
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_sel_basic();
    test_rr_sequence();
    test_rr_wrap();
    test_backpressure();
    test_async_reset();
    test_sel_invalid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
